// File: rtl/code_lock_controller.sv
// code_lock_controller
//   Four-colour code lock sequencer. An attempt starts when S is sampled high
//   in IDLE; four {R,G,B} codes are then captured on consecutive clocks while S
//   stays high, compared with the stored key, and a match holds the door
//   unlock U for OPEN_CYCLES clocks. Consecutive failures are counted and
//   MAX_FAILS of them force a LOCKOUT_CYCLES lockout.
//
//   Optional feature macro: CODE_KEY_PROG_EN
//     defined   : Prog high in OPEN enters PROG, the next four codes become the
//                 new key (kept until reset).
//     undefined : Prog is ignored and the key is fixed at DEFAULT_KEY.
//
// Ports
//   Clk      in   system clock, posedge
//   Rst      in   asynchronous active-low reset
//   S        in   start/hold, must stay high during entry
//   R,G,B    in   colour buttons, sampled together as code {R,G,B}
//   Prog     in   key programming request (only with CODE_KEY_PROG_EN)
//   U        out  door unlock, registered
//   Locked   out  lockout active, registered
//   FailCnt  out  consecutive failed attempts
//   State    out  FSM state encoding (debug)

module code_lock_controller #(
    parameter logic [11:0] DEFAULT_KEY    = 12'h88C,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       S,
    input  logic       R,
    input  logic       G,
    input  logic       B,
    input  logic       Prog,
    output logic       U,
    output logic       Locked,
    output logic [1:0] FailCnt,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_PROG    = 3'd5
    } state_e;

    localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);
    localparam logic [2:0] FAIL_MAX3 = 3'(MAX_FAILS);
    localparam logic [1:0] FAIL_MAX2 = 2'(MAX_FAILS);

    state_e      state_q;
    logic        u_q;
    logic        locked_q;
    logic [1:0]  fail_q;
    logic [1:0]  idx_q;
    logic [11:0] cap_q;
    logic [7:0]  timer_q;

    logic [2:0]  code_d;
    logic [3:0]  base_d;
    logic [2:0]  fail_inc_d;

    assign code_d     = {R, G, B};
    // 3*idx as idx + 2*idx, kept at 4 bits to index the 12-bit capture register
    assign base_d     = {2'b00, idx_q} + {1'b0, idx_q, 1'b0};
    // one bit wider so MAX_FAILS == 3 compares without wrapping
    assign fail_inc_d = {1'b0, fail_q} + 3'd1;

`ifdef CODE_KEY_PROG_EN
    logic [11:0] key_q;
`else
    logic [11:0] key_q;
    logic        prog_unused;
    assign key_q       = DEFAULT_KEY;
    assign prog_unused = Prog;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            u_q      <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= '0;
            idx_q    <= '0;
            cap_q    <= '0;
            timer_q  <= '0;
`ifdef CODE_KEY_PROG_EN
            key_q    <= DEFAULT_KEY;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (S) begin
                        state_q <= ST_ENTRY;
                        idx_q   <= '0;
                    end
                end

                ST_ENTRY: begin
                    if (!S) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cap_q[base_d +: 3] <= code_d;
                        idx_q              <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    if (cap_q == key_q) begin
                        state_q <= ST_OPEN;
                        u_q     <= 1'b1;
                        timer_q <= OPEN_LOAD;
                        fail_q  <= '0;
                    end else if (fail_inc_d == FAIL_MAX3) begin
                        state_q  <= ST_LOCKOUT;
                        locked_q <= 1'b1;
                        timer_q  <= LOCK_LOAD;
                        fail_q   <= FAIL_MAX2;
                    end else begin
                        state_q <= ST_IDLE;
                        fail_q  <= fail_inc_d[1:0];
                    end
                end

                ST_OPEN: begin
`ifdef CODE_KEY_PROG_EN
                    // programming request wins over timer expiry
                    if (Prog) begin
                        state_q <= ST_PROG;
                        u_q     <= 1'b0;
                        idx_q   <= '0;
                    end else
`endif
                    if (timer_q == 8'd1) begin
                        state_q <= ST_IDLE;
                        u_q     <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end

                ST_LOCKOUT: begin
                    if (timer_q == 8'd1) begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end

`ifdef CODE_KEY_PROG_EN
                ST_PROG: begin
                    cap_q[base_d +: 3] <= code_d;
                    idx_q              <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // the 4th code is not yet in cap_q, splice it in directly
                        key_q   <= {code_d, cap_q[8:0]};
                        state_q <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    state_q  <= ST_IDLE;
                    u_q      <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign U       = u_q;
    assign Locked  = locked_q;
    assign FailCnt = fail_q;
    assign State   = state_q;

endmodule

// File: tb/tb_code_lock_controller.sv
`timescale 1ns/1ps

module tb_code_lock_controller;

    logic       Clk;
    logic       Rst;
    logic       S, R, G, B, Prog;
    logic       U, Locked;
    logic [1:0] FailCnt;
    logic [2:0] State;

    code_lock_controller dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .S       (S),
        .R       (R),
        .G       (G),
        .B       (B),
        .Prog    (Prog),
        .U       (U),
        .Locked  (Locked),
        .FailCnt (FailCnt),
        .State   (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       u;
        logic       locked;
        logic [1:0] fail;
        logic [2:0] st;
    } exp_t;

    typedef struct {
        logic [11:0] code;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [11:0] KEY_DEF = 12'h88C;
    localparam logic [11:0] KEY_NEW = 12'h889;
    localparam logic [11:0] KEY_BAD = 12'h48C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic u, input logic l, input logic [1:0] f, input logic [2:0] st);
        exp_t e;
        e.u = u; e.locked = l; e.fail = f; e.st = st;
        return e;
    endfunction

    task automatic wait_open();
        int n = 0;
        int both = 0;
        while (U === 1'b1 && n < 300) begin
            if (Locked !== 1'b0) both++;
            n++;
            @(negedge Clk);
        end
        check("open_len", n, 8);
        check("open_excl", both, 0);
        check("open_exit_state", State, 0);
    endtask

    task automatic wait_lockout();
        int n = 0;
        int bad = 0;
        S = 1'b1;
        while (Locked === 1'b1 && n < 300) begin
            if (State === 3'd1 || U !== 1'b0) bad++;
            n++;
            @(negedge Clk);
        end
        S = 1'b0;
        check("lock_len", n, 16);
        check("lock_no_entry", bad, 0);
        check("lock_exit_state", State, 0);
        check("lock_exit_fail", FailCnt, 0);
    endtask

    // drive one full attempt, sample one cycle after the CHECK edge
    task automatic run_attempt(input logic [11:0] code, input exp_t e, input bit tails);
        exp_t got;
        sb.push_back(e);
        @(negedge Clk);
        S = 1'b1; {R, G, B} = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            {R, G, B} = code[3*i +: 3];
        end
        @(negedge Clk);
        S = 1'b0; {R, G, B} = 3'b000;
        @(negedge Clk);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            check("att_U", U, got.u);
            check("att_Locked", Locked, got.locked);
            check("att_FailCnt", FailCnt, got.fail);
            check("att_State", State, got.st);
        end
        if (tails && e.u) wait_open();
        if (tails && e.locked) wait_lockout();
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        Rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{KEY_DEF, mk(1'b1, 1'b0, 2'd0, 3'd3)};
        tbl[1] = '{KEY_BAD, mk(1'b0, 1'b0, 2'd1, 3'd0)};
        tbl[2] = '{12'h000, mk(1'b0, 1'b0, 2'd2, 3'd0)};
        tbl[3] = '{12'hFFF, mk(1'b0, 1'b1, 2'd3, 3'd4)};
        tbl[4] = '{KEY_DEF, mk(1'b1, 1'b0, 2'd0, 3'd3)};
        tbl[5] = '{KEY_BAD, mk(1'b0, 1'b0, 2'd1, 3'd0)};
        tbl[6] = '{KEY_DEF, mk(1'b1, 1'b0, 2'd0, 3'd3)};

        Rst = 1'b0; S = 1'b0; R = 1'b0; G = 1'b0; B = 1'b0; Prog = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("rst_U", U, 0);
        check("rst_Locked", Locked, 0);
        check("rst_FailCnt", FailCnt, 0);
        check("rst_State", State, 0);

        for (int i = 0; i < 7; i++) begin
            run_attempt(tbl[i].code, tbl[i].e, 1'b1);
        end

        // abort after two codes: FailCnt held, next correct entry opens
        run_attempt(KEY_BAD, mk(1'b0, 1'b0, 2'd1, 3'd0), 1'b1);
        @(negedge Clk);
        S = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            {R, G, B} = KEY_DEF[3*i +: 3];
        end
        @(negedge Clk);
        S = 1'b0; {R, G, B} = 3'b000;
        @(negedge Clk);
        check("abort_State", State, 0);
        check("abort_FailCnt", FailCnt, 1);
        run_attempt(KEY_DEF, mk(1'b1, 1'b0, 2'd0, 3'd3), 1'b1);

        // asynchronous reset in the middle of OPEN
        run_attempt(KEY_DEF, mk(1'b1, 1'b0, 2'd0, 3'd3), 1'b0);
        repeat (2) @(negedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check("rst_open_U", U, 0);
        check("rst_open_State", State, 0);
        check("rst_open_FailCnt", FailCnt, 0);
        @(negedge Clk);
        Rst = 1'b1;

        // asynchronous reset in the middle of LOCKOUT
        run_attempt(KEY_BAD, mk(1'b0, 1'b0, 2'd1, 3'd0), 1'b0);
        run_attempt(KEY_BAD, mk(1'b0, 1'b0, 2'd2, 3'd0), 1'b0);
        run_attempt(KEY_BAD, mk(1'b0, 1'b1, 2'd3, 3'd4), 1'b0);
        repeat (3) @(negedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check("rst_lock_Locked", Locked, 0);
        check("rst_lock_FailCnt", FailCnt, 0);
        check("rst_lock_State", State, 0);
        @(negedge Clk);
        Rst = 1'b1;

        // key programming from OPEN
        run_attempt(KEY_DEF, mk(1'b1, 1'b0, 2'd0, 3'd3), 1'b0);
        Prog = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            Prog = 1'b0;
            {R, G, B} = KEY_NEW[3*i +: 3];
        end
        @(negedge Clk);
        {R, G, B} = 3'b000;
`ifdef CODE_KEY_PROG_EN
        check("prog_State", State, 0);
        check("prog_U", U, 0);
`else
        check("prog_State", State, 3);
        check("prog_U", U, 1);
`endif
        for (int n = 0; n < 20 && U === 1'b1; n++) @(negedge Clk);
        check("prog_idle", State, 0);
`ifdef CODE_KEY_PROG_EN
        run_attempt(KEY_DEF, mk(1'b0, 1'b0, 2'd1, 3'd0), 1'b1);
        run_attempt(KEY_NEW, mk(1'b1, 1'b0, 2'd0, 3'd3), 1'b1);
`else
        run_attempt(KEY_DEF, mk(1'b1, 1'b0, 2'd0, 3'd3), 1'b1);
        run_attempt(KEY_NEW, mk(1'b0, 1'b0, 2'd1, 3'd0), 1'b1);
`endif

        // every code combination from reset, only the default key opens
        for (int k = 0; k < 4096; k++) begin
            logic [11:0] c;
            logic        hit;
            c   = 12'(k);
            hit = (c == KEY_DEF);
            pulse_reset();
            run_attempt(c, mk(hit, 1'b0, hit ? 2'd0 : 2'd1, hit ? 3'd3 : 3'd0), 1'b0);
        end

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
